apb_slave_mem: RTL and testbench
================================

# apb_slave_mem

Word-addressed APB3/APB4 completer memory that sits directly downstream of the APB requester. It consumes one PSELx bit plus PADDR/PWRITE/PWDATA/PENABLE (and PSTRB/PPROT under AMBA4), and returns PRDATA/PREADY/PSLVERR. The number of wait states is programmable. It serves as the bus-functional target for system-level regressions and as a reusable on-chip scratch RAM.

## Interface
- ADDR_WIDTH, 32: PADDR width (from shared_pkg).
- DATA_WIDTH, 32: data width (from shared_pkg); must be 8, 16 or 32.
- MEM_DEPTH, 64: number of DATA_WIDTH words.
- WAIT_STATES, 0: PREADY-low cycles in every access phase, range 0..15.
- PCLK  in  1  clock, all logic on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  this slave's PSELx bit.
- PENABLE  in  1  access phase flag.
- PADDR  in  ADDR_WIDTH  byte address.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte lane enables. Present only under `AMBA4`; otherwise writes are treated as all lanes enabled.
- PPROT  in  3  protection attributes. Present only under `AMBA4`; bit 0 = privileged.
- PRDATA  out  DATA_WIDTH  read data, valid when PREADY=1 and PWRITE=0.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response, valid only when PREADY=1.

## Operation
- FSM states: IDLE, ACCESS.
  - IDLE → ACCESS on PSEL=1 and PENABLE=0 (setup phase). On this edge the block latches PADDR, PWRITE, PWDATA, PSTRB and PPROT, and loads the wait counter with WAIT_STATES.
  - ACCESS: the counter decrements while nonzero. PREADY = (state==ACCESS && cnt==0).
  - ACCESS → IDLE on the completion edge (PSEL & PENABLE & PREADY).
  - ACCESS → IDLE on an abort (PSEL=0 before completion). No write occurs and no response is given.
- Index = latched_addr >> log2(DATA_WIDTH/8).
- Error condition: index ≥ MEM_DEPTH, or addr[log2(DATA_WIDTH/8)-1:0] ≠ 0.
  - Under AMBA4, the top word (index MEM_DEPTH-1) is privileged-only. A write to it with PPROT[0]=0 also raises the error condition.
- Read: PRDATA is registered from the memory at the setup edge and held through ACCESS. It is forced to 0 on error.
- Write: the memory updates on the completion edge only, and only for enabled byte lanes. Errored writes do not modify the memory.
- PSLVERR = error condition gated by PREADY. It is 0 whenever PREADY=0.
- A PENABLE=1 input while in IDLE (protocol violation) is ignored. The FSM stays in IDLE and PREADY stays 0.
- Reset values: state=IDLE, counter=0, PREADY=0, PSLVERR=0, PRDATA=0, all memory words=0.

## Timing
- With WAIT_STATES=N, the setup cycle is T0 and the first access cycle is T1.
  - PREADY rises in cycle T1+N.
  - The transfer completes on the rising edge ending T1+N.
  - Total transfer length is N+2 cycles.
- PREADY is driven from registers only. It has no combinational path from PSEL or PENABLE.
- PREADY drops in the cycle after completion.
- Back-to-back transfers: a new setup in the cycle after completion is accepted, giving no idle bubble.
- A read issued immediately after a write to the same address returns the new data.
- PRESETn assertion mid-transfer forces IDLE immediately, clears all outputs, and clears the memory. The pending write is lost.

## Structure
- shared_pkg holds ADDR_WIDTH, DATA_WIDTH, NO_SLAVES, MEM_DEPTH and the slave_state_e enum {IDLE, ACCESS}.
- Sub-module apb_slave_regfile holds the memory array, the byte-strobe write path and asynchronous clear. It has one write port and one read port.
- The top level contains the FSM, wait counter, address decode and error logic.

## Test plan
- Reset, then write 0xDEADBEEF to addr 0x10 and read addr 0x10 with WAIT_STATES=0 → PREADY high in T1, PRDATA=0xDEADBEEF, PSLVERR=0, 2 cycles per transfer.
- WAIT_STATES=3, read addr 0x04 after reset → PREADY low for 3 access cycles, high on the 4th, PRDATA=0.
- Write to addr 0x100 (index 64) and to addr 0x02 (misaligned) → PSLVERR=1 coincident with PREADY. A read of addr 0x00 then returns its prior value, unchanged.
- AMBA4: word 0x0 holds 0x11223344; write 0xAABBCCDD with PSTRB=4'b0101 → readback 0x11BB33DD. A write to word 63 with PPROT=3'b000 → PSLVERR=1 and the word is unchanged.
- Drop PSEL in the second of 3 wait cycles during a write → no PREADY pulse, memory unchanged, next setup accepted normally.
- Assert PRESETn=0 during ACCESS of a write → PREADY, PSLVERR and PRDATA go to 0 immediately, and after release every address reads 0.

Source files
------------

// File: rtl/shared_pkg.sv
// Shared APB slave parameters and state type.
// Imported by the APB completer memory and its register file.
package shared_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int NO_SLAVES  = 1;
  localparam int MEM_DEPTH  = 64;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } slave_state_e;

endpackage

// File: rtl/apb_slave_regfile.sv
// Word memory with byte-lane write port and async clear.
// One write port, one combinational read port.
module apb_slave_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64,
  parameter int IDX_W      = 6
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_we,
  input  logic [IDX_W-1:0]        i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic [IDX_W-1:0]        i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  // Byte-lane write; reset wipes every word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem <= '{default: '0};
    end else if (i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3/APB4 completer memory with fixed wait states.
// FSM, wait counter, decode and error response.
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = shared_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH  = shared_pkg::DATA_WIDTH,
  parameter int MEM_DEPTH   = shared_pkg::MEM_DEPTH,
  parameter int WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef AMBA4
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
`endif
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  import shared_pkg::*;

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NB - 1);

  slave_state_e r_state;
  slave_state_e w_next;

  logic [3:0]            r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NB-1:0]         r_strb;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [ADDR_WIDTH-1:0] w_idx_full;
  logic                  w_oob;
  logic                  w_mis;
  logic                  w_priv;
  logic                  w_err_in;
  logic [NB-1:0]         w_strb;
  logic                  w_setup;
  logic                  w_ready;
  logic                  w_done;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_idx_full = PADDR >> LSB;
  assign w_oob      = (w_idx_full >= ADDR_WIDTH'(MEM_DEPTH));
  assign w_mis      = |(PADDR & ALIGN_MASK);
`ifdef AMBA4
  assign w_priv = PWRITE & ~PPROT[0]
                & (w_idx_full == ADDR_WIDTH'(MEM_DEPTH - 1));
  assign w_strb = PSTRB;
`else
  assign w_priv = 1'b0;
  assign w_strb = '1;
`endif
  assign w_err_in = w_oob | w_mis | w_priv;

  assign w_setup = PSEL & ~PENABLE;
  assign w_ready = (r_state == ACCESS) && (r_cnt == 4'd0);
  assign w_done  = (r_state == ACCESS) & PSEL & PENABLE & w_ready;
  assign w_we    = w_done & r_write & ~r_err;

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next state: enter on setup, leave on completion or abort.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_setup) w_next = ACCESS;
      end
      ACCESS: begin
        if (!PSEL)                    w_next = IDLE;
        else if (PENABLE && w_ready)  w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Latch the request at setup; count down wait states.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else if (r_state == IDLE && w_setup) begin
      r_cnt   <= 4'(WAIT_STATES);
      r_idx   <= w_idx_full[IDX_W-1:0];
      r_write <= PWRITE;
      r_wdata <= PWDATA;
      r_strb  <= w_strb;
      r_err   <= w_err_in;
      r_rdata <= w_err_in ? '0 : w_rdata;
    end else if (r_state == ACCESS && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  apb_slave_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .i_clk   (PCLK),
    .i_rst_n (PRESETn),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wdata (r_wdata),
    .i_wstrb (r_strb),
    .i_raddr (w_idx_full[IDX_W-1:0]),
    .o_rdata (w_rdata)
  );

  assign PREADY  = w_ready;
  assign PSLVERR = w_ready & r_err;
  assign PRDATA  = r_rdata;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: two instances (0 and 3 wait states),
// vector table plus scoreboard, and abort/reset/protocol sequences.
module tb_apb_slave_mem;

  logic        clk;
  logic        rst_n;
  logic        psel    [2];
  logic        penable [2];
  logic [31:0] paddr   [2];
  logic        pwrite  [2];
  logic [31:0] pwdata  [2];
`ifdef AMBA4
  logic [3:0]  pstrb   [2];
  logic [2:0]  pprot   [2];
`endif
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    int          dut;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] rd;
    logic        err;
    int          waits;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

`ifdef AMBA4
  localparam logic [31:0] STRB_EXP = 32'h11BB33DD;
  localparam logic        PRIV_ERR = 1'b1;
  localparam logic [31:0] PRIV_RD  = 32'h0;
`else
  localparam logic [31:0] STRB_EXP = 32'hAABBCCDD;
  localparam logic        PRIV_ERR = 1'b0;
  localparam logic [31:0] PRIV_RD  = 32'h12345678;
`endif

  apb_slave_mem #(.WAIT_STATES(0)) dut0 (
    .PCLK(clk), .PRESETn(rst_n),
    .PSEL(psel[0]), .PENABLE(penable[0]), .PADDR(paddr[0]),
    .PWRITE(pwrite[0]), .PWDATA(pwdata[0]),
`ifdef AMBA4
    .PSTRB(pstrb[0]), .PPROT(pprot[0]),
`endif
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
  );

  apb_slave_mem #(.WAIT_STATES(3)) dut3 (
    .PCLK(clk), .PRESETn(rst_n),
    .PSEL(psel[1]), .PENABLE(penable[1]), .PADDR(paddr[1]),
    .PWRITE(pwrite[1]), .PWDATA(pwdata[1]),
`ifdef AMBA4
    .PSTRB(pstrb[1]), .PPROT(pprot[1]),
`endif
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int d, logic w, logic [31:0] a,
                              logic [31:0] wd, logic [3:0] s,
                              logic [2:0] p, logic [31:0] rd,
                              logic e);
    vec_t v;
    v.dut = d; v.wr = w; v.addr = a; v.wdata = wd;
    v.strb = s; v.prot = p; v.rd = rd; v.err = e;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one full transfer; expected result is queued at setup
  // and popped when PREADY is seen.
  task automatic xfer(input vec_t v);
    int   d;
    int   w;
    exp_t e;
    d = v.dut;
    w = 0;
    @(negedge clk);
    psel[d] = 1'b1; penable[d] = 1'b0;
    pwrite[d] = v.wr; paddr[d] = v.addr; pwdata[d] = v.wdata;
`ifdef AMBA4
    pstrb[d] = v.strb; pprot[d] = v.prot;
`endif
    e.wr = v.wr; e.rd = v.rd; e.err = v.err;
    e.waits = (d == 1) ? 3 : 0;
    sb.push_back(e);
    @(negedge clk);
    penable[d] = 1'b1;
    while (!pready[d] && w < 20) begin
      @(negedge clk);
      w++;
    end
    e = sb.pop_front();
    if (!pready[d]) begin
      chk("timeout", 32'(w), 32'(e.waits));
      return;
    end
    chk($sformatf("waits@%h", v.addr), 32'(w), 32'(e.waits));
    chk($sformatf("slverr@%h", v.addr), 32'(pslverr[d]), 32'(e.err));
    if (!e.wr) chk($sformatf("rdata@%h", v.addr), prdata[d], e.rd);
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    psel[d] = 1'b0; penable[d] = 1'b0;
    chk("ready_drop", 32'(pready[d]), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 0; penable[d] = 0; paddr[d] = 0;
      pwrite[d] = 0; pwdata[d] = 0;
`ifdef AMBA4
      pstrb[d] = 4'hF; pprot[d] = 3'b001;
`endif
    end

    // dut 0: zero wait states
    vt.push_back(mk(0, 0, 32'h10, 0, 4'hF, 3'b001, 32'h0, 0));
    vt.push_back(mk(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b001, 0, 0));
    vt.push_back(mk(0, 0, 32'h10, 0, 4'hF, 3'b001, 32'hDEADBEEF, 0));
    vt.push_back(mk(0, 1, 32'h100, 32'h55, 4'hF, 3'b001, 0, 1));
    vt.push_back(mk(0, 1, 32'h02, 32'h66, 4'hF, 3'b001, 0, 1));
    vt.push_back(mk(0, 0, 32'h00, 0, 4'hF, 3'b001, 32'h0, 0));
    vt.push_back(mk(0, 0, 32'h100, 0, 4'hF, 3'b001, 32'h0, 1));
    vt.push_back(mk(0, 0, 32'hFC, 0, 4'hF, 3'b001, 32'h0, 0));
    vt.push_back(mk(0, 1, 32'h00, 32'h11223344, 4'hF, 3'b001, 0, 0));
    vt.push_back(mk(0, 0, 32'h00, 0, 4'hF, 3'b001, 32'h11223344, 0));
    vt.push_back(mk(0, 1, 32'h00, 32'hAABBCCDD, 4'h5, 3'b001, 0, 0));
    vt.push_back(mk(0, 0, 32'h00, 0, 4'hF, 3'b001, STRB_EXP, 0));
    vt.push_back(mk(0, 1, 32'hFC, 32'h12345678, 4'hF, 3'b000, 0,
                    PRIV_ERR));
    vt.push_back(mk(0, 0, 32'hFC, 0, 4'hF, 3'b000, PRIV_RD, 0));
    vt.push_back(mk(0, 1, 32'hFC, 32'hCAFEF00D, 4'hF, 3'b001, 0, 0));
    vt.push_back(mk(0, 0, 32'hFC, 0, 4'hF, 3'b001, 32'hCAFEF00D, 0));
    vt.push_back(mk(0, 0, 32'h03, 0, 4'hF, 3'b001, 32'h0, 1));
    // dut 1: three wait states
    vt.push_back(mk(1, 0, 32'h04, 0, 4'hF, 3'b001, 32'h0, 0));
    vt.push_back(mk(1, 1, 32'h08, 32'hA5A5A5A5, 4'hF, 3'b001, 0, 0));
    vt.push_back(mk(1, 0, 32'h08, 0, 4'hF, 3'b001, 32'hA5A5A5A5, 0));

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 32'(pready[d]), 32'h0);
      chk("rst_slverr", 32'(pslverr[d]), 32'h0);
      chk("rst_rdata", prdata[d], 32'h0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      xfer(vt[i]);
      if (i + 1 == vt.size() || vt[i+1].dut != vt[i].dut)
        idle(vt[i].dut);
    end

    // PENABLE without setup while idle is ignored
    @(negedge clk);
    psel[0] = 1; penable[0] = 1; pwrite[0] = 1;
    paddr[0] = 32'h10; pwdata[0] = 32'h00000BAD;
    repeat (3) begin
      @(negedge clk);
      chk("viol_ready", 32'(pready[0]), 32'h0);
    end
    psel[0] = 0; penable[0] = 0;
    xfer(mk(0, 0, 32'h10, 0, 4'hF, 3'b001, 32'hDEADBEEF, 0));
    idle(0);

    // abort in the second wait cycle of a write
    @(negedge clk);
    psel[1] = 1; penable[1] = 0; pwrite[1] = 1;
    paddr[1] = 32'h20; pwdata[1] = 32'h77;
    @(negedge clk);
    penable[1] = 1;
    chk("abort_t1", 32'(pready[1]), 32'h0);
    @(negedge clk);
    chk("abort_t2", 32'(pready[1]), 32'h0);
    psel[1] = 0; penable[1] = 0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_idle", 32'(pready[1]), 32'h0);
    end
    xfer(mk(1, 0, 32'h20, 0, 4'hF, 3'b001, 32'h0, 0));
    idle(1);

    // reset during the access phase of a write
    xfer(mk(1, 0, 32'h08, 0, 4'hF, 3'b001, 32'hA5A5A5A5, 0));
    @(negedge clk);
    psel[1] = 1; penable[1] = 0; pwrite[1] = 1;
    paddr[1] = 32'h08; pwdata[1] = 32'h5A5A0000;
    @(negedge clk);
    penable[1] = 1;
    chk("pre_rst_rdata", prdata[1], 32'hA5A5A5A5);
    chk("pre_rst_ready", 32'(pready[1]), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(pready[1]), 32'h0);
    chk("mid_rst_slverr", 32'(pslverr[1]), 32'h0);
    chk("mid_rst_rdata1", prdata[1], 32'h0);
    chk("mid_rst_rdata0", prdata[0], 32'h0);
    @(negedge clk);
    psel[1] = 0; penable[1] = 0;
    rst_n = 1'b1;
    xfer(mk(0, 0, 32'h00, 0, 4'hF, 3'b001, 32'h0, 0));
    xfer(mk(0, 0, 32'h10, 0, 4'hF, 3'b001, 32'h0, 0));
    xfer(mk(0, 0, 32'hFC, 0, 4'hF, 3'b001, 32'h0, 0));
    idle(0);
    xfer(mk(1, 0, 32'h08, 0, 4'hF, 3'b001, 32'h0, 0));
    xfer(mk(1, 0, 32'h04, 0, 4'hF, 3'b001, 32'h0, 0));
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
